// File: rtl/resolution_text_renderer_if.sv
// Video-side bus of the resolution text renderer: timing strobes, window origin,
// ROM row port and the rendered pixel outputs.
interface resolution_text_renderer_if #(
  parameter int HW        = 12,
  parameter int VW        = 11,
  parameter int LINE_BITS = 136
);
  logic                 pixel_en;
  logic                 frame_start;
  logic                 line_start;
  logic [HW-1:0]        hpos;
  logic [VW-1:0]        vpos;
  logic [HW-1:0]        start_x;
  logic [VW-1:0]        start_y;
  logic [3:0]           rom_addr;
  logic [LINE_BITS-1:0] rom_q;
  logic                 pixel_on;
  logic                 text_active;
  logic                 shadow_on;
  logic                 late_err;

  modport master (
    output pixel_en, frame_start, line_start, hpos, vpos, start_x, start_y, rom_q,
    input  rom_addr, pixel_on, text_active, shadow_on, late_err
  );

  modport slave (
    input  pixel_en, frame_start, line_start, hpos, vpos, start_x, start_y, rom_q,
    output rom_addr, pixel_on, text_active, shadow_on, late_err
  );
endinterface

// File: rtl/resolution_text_renderer.sv
// Fetches one bitmap row from the resolution char ROM per video line and shifts it out MSB-first
// as a pixel mask inside a window. Define RESTEXT_SHADOW_EN to enable the drop-shadow output.
module resolution_text_renderer #(
  parameter int LINE_BITS  = 136,
  parameter int SCALE_LOG2 = 0,
  parameter int HW         = 12,
  parameter int VW         = 11
) (
  input logic                       clock,
  input logic                       reset,
  resolution_text_renderer_if.slave bus
);
  localparam int CW = $clog2(LINE_BITS);
  localparam int RW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam logic [RW-1:0] REP_LAST = RW'((1 << SCALE_LOG2) - 1);
  localparam logic [VW-1:0] WIN_ROWS = VW'(16 << SCALE_LOG2);
  localparam logic [CW-1:0] CNT_INIT = CW'(LINE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ARMED = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [LINE_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        bitcnt_q, bitcnt_d;
  logic [RW-1:0]        rep_q, rep_d;
  logic [HW-1:0]        sx_q, sx_d;
  logic [VW-1:0]        sy_q, sy_d;
  logic [3:0]           rom_addr_q, rom_addr_d;
  logic                 pixel_on_q, pixel_on_d;
  logic                 text_active_q, text_active_d;
  logic                 shadow_on_q, shadow_on_d;
  logic                 late_err_q, late_err_d;

  logic [VW-1:0] sy_eff_s;
  logic [VW-1:0] dist_s;
  logic          in_win_s;
  logic [3:0]    row_s;
  logic          late_s;
  logic          late_set_s;
  logic          emit_s;
  logic          cur_bit_s;
  logic          shade_s;
  logic          done_shade_s;

  // Next-state and output computation for the row fetch / shift sequencer.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bitcnt_d      = bitcnt_q;
    rep_d         = rep_q;
    rom_addr_d    = rom_addr_q;
    pixel_on_d    = pixel_on_q;
    text_active_d = text_active_q;
    shadow_on_d   = shadow_on_q;
    late_set_s    = 1'b0;
    emit_s        = 1'b0;

    // A line_start in the frame_start cycle must already see the new origin.
    sy_eff_s   = bus.frame_start ? bus.start_y : sy_q;
    sx_d       = bus.frame_start ? bus.start_x : sx_q;
    sy_d       = sy_eff_s;
    dist_s     = bus.vpos - sy_eff_s;
    in_win_s   = (bus.vpos >= sy_eff_s) && (dist_s < WIN_ROWS);
    row_s      = 4'(dist_s >> SCALE_LOG2);
    late_s     = bus.pixel_en && (bus.hpos > sx_q);
    cur_bit_s  = shreg_q[LINE_BITS-1];
`ifdef RESTEXT_SHADOW_EN
    shade_s      = ~cur_bit_s & pixel_on_q;
    done_shade_s = pixel_on_q;
`else
    shade_s      = 1'b0;
    done_shade_s = 1'b0;
`endif

    if (bus.line_start) begin
      pixel_on_d    = 1'b0;
      text_active_d = 1'b0;
      shadow_on_d   = 1'b0;
      if (in_win_s) begin
        state_d    = S_FETCH;
        rom_addr_d = row_s;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_FETCH: begin
          if (late_s) begin
            late_set_s = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (late_s) begin
            late_set_s = 1'b1;
            state_d    = S_IDLE;
          end else begin
            shreg_d  = bus.rom_q;
            bitcnt_d = CNT_INIT;
            rep_d    = {RW{1'b0}};
            state_d  = S_ARMED;
          end
        end
        S_ARMED: begin
          if (late_s) begin
            late_set_s = 1'b1;
            state_d    = S_IDLE;
          end else if (bus.pixel_en && (bus.hpos == sx_q)) begin
            emit_s = 1'b1;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_SHIFT: emit_s = bus.pixel_en;
        S_DONE: begin
          if (bus.pixel_en) begin
            pixel_on_d    = 1'b0;
            text_active_d = 1'b0;
            shadow_on_d   = done_shade_s;
          end else begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (emit_s) begin
        pixel_on_d    = cur_bit_s;
        text_active_d = 1'b1;
        shadow_on_d   = shade_s;
        if (rep_q == REP_LAST) begin
          rep_d    = {RW{1'b0}};
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q - CW'(1);
          state_d  = (bitcnt_q == {CW{1'b0}}) ? S_DONE : S_SHIFT;
        end else begin
          rep_d   = rep_q + RW'(1);
          state_d = S_SHIFT;
        end
      end else begin
        rep_d = rep_d;
      end
    end

    late_err_d = bus.frame_start ? 1'b0 : (late_err_q | late_set_s);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shreg_q       <= {LINE_BITS{1'b0}};
      bitcnt_q      <= {CW{1'b0}};
      rep_q         <= {RW{1'b0}};
      sx_q          <= {HW{1'b0}};
      sy_q          <= {VW{1'b0}};
      rom_addr_q    <= 4'd0;
      pixel_on_q    <= 1'b0;
      text_active_q <= 1'b0;
      shadow_on_q   <= 1'b0;
      late_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      rep_q         <= rep_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      rom_addr_q    <= rom_addr_d;
      pixel_on_q    <= pixel_on_d;
      text_active_q <= text_active_d;
      shadow_on_q   <= shadow_on_d;
      late_err_q    <= late_err_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.pixel_on    = pixel_on_q;
  assign bus.text_active = text_active_q;
  assign bus.shadow_on   = shadow_on_q;
  assign bus.late_err    = late_err_q;
endmodule
